elevator_floor_ctrl: RTL

//  Car controller for the elevator simulator. Latches floor-call buttons and moves the car one floor at a time.

---
 rtl/elevator_floor_ctrl_pkg.sv | 34 +++
 rtl/elevator_floor_ctrl_if.sv | 24 ++
 rtl/elevator_cycle_timer.sv | 30 +++
 rtl/elevator_floor_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/elevator_floor_ctrl_pkg.sv
// rtl/elevator_floor_ctrl_pkg.sv - shared types, constants and floor-mask helpers for the elevator car controller
package elevator_floor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_t;

    localparam int   FLOOR_W = 4;
    localparam int   TIMER_W = 16;
    localparam logic UP      = 1'b1;
    localparam logic DN      = 1'b0;

    // Floors strictly above f, over the full 16-floor space
    function automatic logic [15:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    // Floors strictly below f
    function automatic logic [15:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = (i < int'(f));
        return m;
    endfunction

    function automatic logic [15:0] onehot(input logic [FLOOR_W-1:0] f);
        return 16'(1) << f;
    endfunction

endpackage

// File: rtl/elevator_floor_ctrl_if.sv
// rtl/elevator_floor_ctrl_if.sv - call buttons in, car status out
interface elevator_floor_ctrl_if
    import elevator_floor_ctrl_pkg::*;
#(
    parameter int NUM_FLOORS = 8
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    floor;
    logic                  disp_en;
    logic                  moving_up;
    logic                  moving_dn;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output call_req,
        input  floor, disp_en, moving_up, moving_dn, door_open, pending
    );

    modport slave (
        input  call_req,
        output floor, disp_en, moving_up, moving_dn, door_open, pending
    );
endinterface

// File: rtl/elevator_cycle_timer.sv
// rtl/elevator_cycle_timer.sv - loadable down-counter shared by travel and door timing
module elevator_cycle_timer
    import elevator_floor_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic [TIMER_W-1:0] count_next,
    output logic               done
);
    logic [TIMER_W-1:0] count_q;

    // Reload on request, otherwise count down and park at zero
    always_comb begin
        count_next = count_q;
        if (load)
            count_next = load_val;
        else if (count_q != '0)
            count_next = count_q - TIMER_W'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_next;
    end

    assign done = (count_q == '0);
endmodule

// File: rtl/elevator_floor_ctrl.sv
// rtl/elevator_floor_ctrl.sv - elevator car FSM with call latching; FLOOR_BLINK_EN blinks the display in travel
module elevator_floor_ctrl
    import elevator_floor_ctrl_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
)(
    input  logic                 clk,
    input  logic                 reset_n,
    elevator_floor_ctrl_if.slave bus
);
`ifdef FLOOR_BLINK_EN
    localparam int BLINK_FROM = TRAVEL_CYCLES / 2;
`else
    // Elapsed travel count never reaches this, so the display stays on
    localparam int BLINK_FROM = TRAVEL_CYCLES;
`endif

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d, floor_up, floor_dn, clr_floor;
    logic                  last_dir_q, last_dir_d, clr_en;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic [15:0]           eff;
    logic                  call_here, eff_here, eff_up, eff_dn;
    logic                  any_above, any_below, further_up, further_dn;
    logic                  tmr_load, tmr_done;
    logic [TIMER_W-1:0]    tmr_load_val, tmr_count_next, elapsed;
    logic                  moving_up_q, moving_dn_q, door_open_q, disp_en_q;
    logic                  moving_up_d, moving_dn_d, door_open_d, disp_en_d;

    // A call seen this cycle counts immediately, so a call at the current floor opens with latency 1
    assign eff        = 16'(pend_q) | 16'(bus.call_req);
    assign floor_up   = floor_q + FLOOR_W'(1);
    assign floor_dn   = floor_q - FLOOR_W'(1);
    assign call_here  = |(16'(bus.call_req) & onehot(floor_q));
    assign eff_here   = |(eff & onehot(floor_q));
    assign eff_up     = |(eff & onehot(floor_up));
    assign eff_dn     = |(eff & onehot(floor_dn));
    assign any_above  = |(eff & above_mask(floor_q));
    assign any_below  = |(eff & below_mask(floor_q));
    assign further_up = |(eff & above_mask(floor_up));
    assign further_dn = |(eff & below_mask(floor_dn));

    elevator_cycle_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_val   (tmr_load_val),
        .count_next (tmr_count_next),
        .done       (tmr_done)
    );

    // State, position and latched calls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            last_dir_q  <= UP;
            pend_q      <= '0;
            moving_up_q <= 1'b0;
            moving_dn_q <= 1'b0;
            door_open_q <= 1'b0;
            disp_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            last_dir_q  <= last_dir_d;
            pend_q      <= pend_d;
            moving_up_q <= moving_up_d;
            moving_dn_q <= moving_dn_d;
            door_open_q <= door_open_d;
            disp_en_q   <= disp_en_d;
        end
    end

    // Next-state: dispatch from IDLE, step floors when travel time expires, hold the door
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        last_dir_d = last_dir_q;
        tmr_load   = 1'b0;
        clr_en     = 1'b0;
        clr_floor  = floor_q;
        case (state_q)
            IDLE: begin
                tmr_load = 1'b1;
                if (eff_here) begin
                    state_d = DOOR;
                    clr_en  = 1'b1;
                end else if (last_dir_q == UP && any_above) state_d = MOVE_UP;
                else if (any_below)                        state_d = MOVE_DN;
                else if (any_above)                        state_d = MOVE_UP;
                else                                       tmr_load = 1'b0;
            end
            MOVE_UP: if (tmr_done) begin
                floor_d    = floor_up;
                last_dir_d = UP;
                tmr_load   = 1'b1;
                clr_floor  = floor_up;
                if (eff_up) begin
                    state_d = DOOR;
                    clr_en  = 1'b1;
                end else if (!further_up) state_d = IDLE;
            end
            MOVE_DN: if (tmr_done) begin
                floor_d    = floor_dn;
                last_dir_d = DN;
                tmr_load   = 1'b1;
                clr_floor  = floor_dn;
                if (eff_dn) begin
                    state_d = DOOR;
                    clr_en  = 1'b1;
                end else if (!further_dn) state_d = IDLE;
            end
            DOOR: begin
                if (call_here) begin
                    tmr_load = 1'b1;
                    clr_en   = 1'b1;
                end else if (tmr_done) begin
                    state_d  = IDLE;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        tmr_load_val = (state_d == DOOR) ? TIMER_W'(DOOR_CYCLES - 1) : TIMER_W'(TRAVEL_CYCLES - 1);
        pend_d = (pend_q | bus.call_req) &
                 ~(clr_en ? NUM_FLOORS'(onehot(clr_floor)) : {NUM_FLOORS{1'b0}});
    end

    // Registered status outputs derived from the upcoming state and timer value
    always_comb begin
        moving_up_d = (state_d == MOVE_UP);
        moving_dn_d = (state_d == MOVE_DN);
        door_open_d = (state_d == DOOR);
        elapsed     = TIMER_W'(TRAVEL_CYCLES - 1) - tmr_count_next;
        disp_en_d   = !((moving_up_d || moving_dn_d) && (elapsed >= TIMER_W'(BLINK_FROM)));
    end

    assign bus.floor     = floor_q;
    assign bus.pending   = pend_q;
    assign bus.moving_up = moving_up_q;
    assign bus.moving_dn = moving_dn_q;
    assign bus.door_open = door_open_q;
    assign bus.disp_en   = disp_en_q;
endmodule
